fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction fetch stage directly upstream of the datapath's decode/execute logic. Holds the architectural PC, issues word fetches to instruction memory over a req/gnt/rvalid handshake, and applies branch/jump redirects (PCSrc, PCTarget). Delivers fetched instructions through an IF/ID pipeline register with stall and bubble support and a one-entry skid buffer.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0013, instruction driven on if_id_instr when the IF/ID register is invalid or reset (addi x0,x0,0).

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
PCSrc  input  1  redirect request from the datapath; 1 = load PCTarget
PCTarget  input  32  redirect target; bits [1:0] ignored and forced to 0
stall  input  1  downstream hold; 1 = IF/ID must keep its contents
PC  output  32  current fetch PC (pc_q)
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch address, equals pc_q
imem_gnt  input  1  memory accepts the request this cycle; may be combinational on imem_req
imem_rvalid  input  1  read data valid; earliest one cycle after grant
imem_rdata  input  32  instruction word
if_id_valid  output  1  IF/ID holds a real instruction
if_id_instr  output  32  registered instruction
if_id_pc  output  32  PC of if_id_instr
if_id_pc_plus4  output  32  if_id_pc + 4

Behaviour:
- Reset (reset=1 at a clock edge, any state): pc_q=RESET_PC, state=REQ, if_id_valid=0, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_pc_plus4=0, skid buffer empty. imem_req low during the reset cycle. Any imem_rvalid arriving in REQ state (e.g. from a request in flight at reset) is ignored.
- States: REQ, WAIT, DRAIN.
- REQ: imem_req = !buf_valid && !PCSrc && !reset (combinational); imem_addr = pc_q, stable while imem_req && !imem_gnt. If imem_req && imem_gnt then WAIT.
- WAIT: imem_req=0. On imem_rvalid, the response is accepted: pc_q <= pc_q+4 (32-bit wrap: 0xFFFFFFFC -> 0x00000000), state=REQ.
  - If the IF/ID register can load (stall=0 or if_id_valid=0), load IF/ID with {1, rdata, pc_q, pc_q+4}.
  - Otherwise write the skid buffer.
- DRAIN: waits for one imem_rvalid, discards the data, then goes to REQ. pc_q is not incremented.
- At most one request is outstanding. Throughput is 1 instruction per 2 cycles with a zero-wait memory. No new request is issued while buf_valid=1, so a response never collides with a full buffer.
- IF/ID update when no response is accepted:
  - stall=0 and buf_valid=1: load IF/ID from the buffer and clear buf_valid.
  - stall=0, no source: if_id_valid <= 0 (bubble); instr <= NOP_INSTR.
  - stall=1: hold all IF/ID fields.
- Redirect (PCSrc=1) has highest priority below reset. It overrides stall and any response in the same cycle.
  - pc_q <= {PCTarget[31:2],2'b00}; if_id_valid <= 0; instr <= NOP_INSTR; buf_valid <= 0.
  - In REQ: no request issued this cycle; stay REQ.
  - In WAIT: if imem_rvalid is asserted in the same cycle, drop it and go to REQ; otherwise go to DRAIN.
  - In DRAIN: update pc_q, stay DRAIN. A same-cycle rvalid is dropped and the state goes to REQ.
- PCSrc repeated on consecutive cycles: the last target wins.
- Latency from fetch address to if_id_valid (zero-wait memory, no stall): 2 cycles after the REQ cycle.

Test Plan:
1. Reset, zero-wait memory returning addr-based words, stall=0 -> imem_addr 0x0, 0x4, 0x8 on every other cycle. IF/ID shows (pc 0x0, plus4 0x4), then 0x4, 0x8 with the matching instrs. PC=RESET_PC in the first cycle after reset.
2. Assert stall for 4 cycles while IF/ID holds pc 0x4 and the 0x8 response arrives -> IF/ID stays at 0x4, buf holds 0x8, imem_req=0. On stall release, IF/ID=0x8 next cycle, then fetch 0xC resumes.
3. PCSrc=1 with PCTarget=0x103 while in WAIT with rvalid delayed 3 cycles -> state DRAIN, if_id_valid=0, the late response is discarded, and the next imem_addr is 0x100.
4. PCSrc=1 in the same cycle as rvalid and stall=1 with buf empty -> data dropped, buf empty, IF/ID invalid, pc_q=target.
5. RESET_PC=0xFFFFFFFC -> second fetch address is 0x00000000 and if_id_pc_plus4=0x00000000 for the first instruction.
6. Reset asserted mid-WAIT, memory rvalid arrives 1 cycle later -> response ignored, if_id_valid stays 0, the refetch of RESET_PC is issued.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Instruction-memory fetch bus: one-outstanding req/gnt/rvalid handshake.
//   imem_req    : fetch request valid (fetch side)
//   imem_addr   : word-aligned fetch address (fetch side)
//   imem_gnt    : request accepted this cycle; may depend combinationally on imem_req
//   imem_rvalid : read data valid, earliest one cycle after grant
//   imem_rdata  : instruction word
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: holds the PC, fetches words from instruction memory,
// applies branch/jump redirects and presents instructions in an IF/ID register
// backed by a one-entry skid buffer for responses that arrive during a stall.
//   clk, reset      : clock, synchronous active-high reset
//   PCSrc, PCTarget : redirect request and target (target bits [1:0] ignored)
//   stall           : downstream hold of the IF/ID register
//   PC              : current fetch PC
//   imem            : instruction-memory bus (master side)
//   if_id_*         : IF/ID register (valid, instruction, PC, PC+4)
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 PCSrc,
    input  logic [31:0]          PCTarget,
    input  logic                 stall,
    output logic [31:0]          PC,
    fetch_stage_if.master        imem,
    output logic                 if_id_valid,
    output logic [31:0]          if_id_instr,
    output logic [31:0]          if_id_pc,
    output logic [31:0]          if_id_pc_plus4
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
    } entry_t;

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_ifid_valid;
    entry_t          r_ifid;
    logic            r_buf_valid;
    entry_t          r_buf;

    state_t          w_state_nxt;
    logic [XLEN-1:0] w_pc_nxt;
    logic            w_ifid_valid_nxt;
    entry_t          w_ifid_nxt;
    logic            w_buf_valid_nxt;
    entry_t          w_buf_nxt;
    logic            w_req;
    logic            w_accept;
    logic [XLEN-1:0] w_pc_plus4;
    logic            w_unused_target_lsbs;

    assign w_unused_target_lsbs = &{1'b0, PCTarget[1:0]};
    assign w_pc_plus4           = r_pc + XLEN'(4);

    // State and pipeline registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_REQ;
            r_pc         <= RESET_PC;
            r_ifid_valid <= 1'b0;
            r_ifid       <= '{instr: NOP_INSTR, pc: '0, pc_plus4: '0};
            r_buf_valid  <= 1'b0;
            r_buf        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_ifid_valid <= w_ifid_valid_nxt;
            r_ifid       <= w_ifid_nxt;
            r_buf_valid  <= w_buf_valid_nxt;
            r_buf        <= w_buf_nxt;
        end
    end

    // Next-state, PC, IF/ID and skid-buffer logic
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_ifid_valid_nxt = r_ifid_valid;
        w_ifid_nxt       = r_ifid;
        w_buf_valid_nxt  = r_buf_valid;
        w_buf_nxt        = r_buf;
        w_req            = 1'b0;
        w_accept         = 1'b0;

        case (r_state)
            S_REQ: begin
                // No request while the buffer is occupied, so a response can never find it full
                w_req = !r_buf_valid && !PCSrc && !reset;
                if (w_req && imem.imem_gnt) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem.imem_rvalid) begin
                    w_state_nxt = S_REQ;
                    w_accept    = !PCSrc;
                end else if (PCSrc) begin
                    // Response still in flight belongs to the old path: swallow it
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (imem.imem_rvalid) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_REQ;
            end
        endcase

        if (PCSrc) begin
            // Redirect flushes everything fetched on the old path, even under stall
            w_pc_nxt              = {PCTarget[XLEN-1:2], 2'b00};
            w_ifid_valid_nxt      = 1'b0;
            w_ifid_nxt.instr      = NOP_INSTR;
            w_buf_valid_nxt       = 1'b0;
        end else if (w_accept) begin
            w_pc_nxt = w_pc_plus4;
            if (!stall || !r_ifid_valid) begin
                w_ifid_valid_nxt = 1'b1;
                w_ifid_nxt       = '{instr: imem.imem_rdata, pc: r_pc, pc_plus4: w_pc_plus4};
            end else begin
                w_buf_valid_nxt  = 1'b1;
                w_buf_nxt        = '{instr: imem.imem_rdata, pc: r_pc, pc_plus4: w_pc_plus4};
            end
        end else if (!stall) begin
            if (r_buf_valid) begin
                w_ifid_valid_nxt = 1'b1;
                w_ifid_nxt       = r_buf;
                w_buf_valid_nxt  = 1'b0;
            end else begin
                w_ifid_valid_nxt = 1'b0;
                w_ifid_nxt.instr = NOP_INSTR;
            end
        end
    end

    assign PC             = r_pc;
    assign imem.imem_req  = w_req;
    assign imem.imem_addr = r_pc;
    assign if_id_valid    = r_ifid_valid;
    assign if_id_instr    = r_ifid.instr;
    assign if_id_pc       = r_ifid.pc;
    assign if_id_pc_plus4 = r_ifid.pc_plus4;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a per-cycle memory model with programmable response
// latency, and a scoreboard of expected IF/ID entries pushed at grant time and
// popped whenever the IF/ID register loads a new instruction.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, PCSrc, stall, gnt_en;
    logic [31:0] PCTarget;
    logic [31:0] pc0, instr0, ipc0, ip40;
    logic [31:0] pc1, instr1, ipc1, ip41;
    logic        v0, v1;

    fetch_stage_if ifc0();
    fetch_stage_if ifc1();

    assign ifc0.imem_gnt = ifc0.imem_req & gnt_en;
    assign ifc1.imem_gnt = ifc1.imem_req;

    fetch_stage u_dut0 (
        .clk(clk), .reset(reset), .PCSrc(PCSrc), .PCTarget(PCTarget), .stall(stall),
        .PC(pc0), .imem(ifc0), .if_id_valid(v0), .if_id_instr(instr0),
        .if_id_pc(ipc0), .if_id_pc_plus4(ip40)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut1 (
        .clk(clk), .reset(reset), .PCSrc(PCSrc), .PCTarget(PCTarget), .stall(stall),
        .PC(pc1), .imem(ifc1), .if_id_valid(v1), .if_id_instr(instr1),
        .if_id_pc(ipc1), .if_id_pc_plus4(ip41)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] fire_q[$];
    logic [31:0] fire1_q[$];
    bit          m_pend [2];
    int          m_cnt  [2];
    int          m_lat  [2];
    logic [31:0] m_addr [2];
    logic        s_req, s_req1;
    logic [31:0] s_addr, s_addr1;
    int          n_checks, n_pass, n_delivered;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // One clock cycle: present memory responses, sample the request, clock, then
    // advance the memory model and the scoreboard.
    task automatic step();
        logic        f0, f1, st, rd, pv;
        logic [31:0] a0, a1;
        exp_t        e;
        ifc0.imem_rvalid = m_pend[0] && (m_cnt[0] == 0);
        ifc0.imem_rdata  = ifc0.imem_rvalid ? mem_word(m_addr[0]) : 32'h0;
        ifc1.imem_rvalid = m_pend[1] && (m_cnt[1] == 0);
        ifc1.imem_rdata  = ifc1.imem_rvalid ? mem_word(m_addr[1]) : 32'h0;
        #1;
        s_req  = ifc0.imem_req;  s_addr  = ifc0.imem_addr;
        s_req1 = ifc1.imem_req;  s_addr1 = ifc1.imem_addr;
        f0 = s_req && ifc0.imem_gnt;   a0 = s_addr;
        f1 = s_req1 && ifc1.imem_gnt;  a1 = s_addr1;
        st = stall; rd = PCSrc || reset; pv = v0;
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            if (m_pend[k]) begin
                if (m_cnt[k] == 0) m_pend[k] = 1'b0;
                else m_cnt[k]--;
            end
        end
        if (f0) begin m_pend[0] = 1'b1; m_cnt[0] = m_lat[0] - 1; m_addr[0] = a0; fire_q.push_back(a0); end
        if (f1) begin m_pend[1] = 1'b1; m_cnt[1] = m_lat[1] - 1; m_addr[1] = a1; fire1_q.push_back(a1); end
        // A redirect or reset discards everything not yet delivered
        if (rd) exp_q.delete();
        else if (f0) exp_q.push_back('{mem_word(a0), a0, a0 + 32'd4});
        // IF/ID takes a new instruction only when it was free to load
        if (v0 && (!st || !pv)) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected: got instr=%h pc=%h, required no instruction", instr0, ipc0);
            end else begin
                e = exp_q.pop_front();
                n_delivered++;
                if (instr0 !== e.instr || ipc0 !== e.pc || ip40 !== e.pc4)
                    $display("FAIL sb_ifid: got instr=%h pc=%h pc4=%h, required instr=%h pc=%h pc4=%h",
                             instr0, ipc0, ip40, e.instr, e.pc, e.pc4);
                else n_pass++;
            end
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1; PCSrc = 1'b0; stall = 1'b0; PCTarget = 32'h0;
        step();
        reset = 1'b0;
        fire_q.delete(); fire1_q.delete(); n_delivered = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1; PCSrc = 1'b0; stall = 1'b0;
        step();
        n_checks++; if (s_req !== 1'b0) $display("FAIL reset_req: got %b, required 0", s_req); else n_pass++;
        n_checks++; if (pc0 !== 32'h0) $display("FAIL reset_pc: got %h, required 00000000", pc0); else n_pass++;
        n_checks++; if (v0 !== 1'b0 || instr0 !== NOP) $display("FAIL reset_ifid: got v=%b instr=%h, required v=0 instr=%h", v0, instr0, NOP); else n_pass++;
        n_checks++; if (ipc0 !== 32'h0 || ip40 !== 32'h0) $display("FAIL reset_ifid_pc: got pc=%h pc4=%h, required 0/0", ipc0, ip40); else n_pass++;
        n_checks++; if (pc1 !== 32'hFFFF_FFFC) $display("FAIL reset_pc_param: got %h, required fffffffc", pc1); else n_pass++;
        reset = 1'b0;
        exp_q.delete(); fire_q.delete(); n_delivered = 0;
        step();
        n_checks++; if (s_req !== 1'b1 || s_addr !== 32'h0) $display("FAIL first_req: got req=%b addr=%h, required 1/00000000", s_req, s_addr); else n_pass++;
    endtask

    task automatic test_fetch();
        logic [31:0] exp_addr [3];
        logic [5:0]  req_pat;
        exp_addr = '{32'h0, 32'h4, 32'h8};
        apply_reset();
        gnt_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++; if (s_req !== 1'b1 || s_addr !== 32'h0) $display("FAIL hold_addr: got req=%b addr=%h, required 1/00000000", s_req, s_addr); else n_pass++;
        end
        gnt_en = 1'b1;
        req_pat = '0;
        for (int i = 0; i < 6; i++) begin
            step();
            req_pat[i] = s_req;
        end
        n_checks++; if (req_pat !== 6'b010101) $display("FAIL req_pattern: got %b, required 010101", req_pat); else n_pass++;
        n_checks++;
        if (fire_q.size() != 3) $display("FAIL fetch_count: got %0d, required 3", fire_q.size());
        else n_pass++;
        for (int i = 0; i < 3 && i < fire_q.size(); i++) begin
            n_checks++; if (fire_q[i] !== exp_addr[i]) $display("FAIL fetch_addr%0d: got %h, required %h", i, fire_q[i], exp_addr[i]); else n_pass++;
        end
        n_checks++; if (pc0 !== 32'hC) $display("FAIL fetch_pc: got %h, required 0000000c", pc0); else n_pass++;
        n_checks++; if (n_delivered != 3 || exp_q.size() != 0) $display("FAIL fetch_delivered: got %0d left %0d, required 3 left 0", n_delivered, exp_q.size()); else n_pass++;
    endtask

    task automatic test_stall();
        apply_reset();
        for (int i = 0; i < 4; i++) step();
        n_checks++; if (v0 !== 1'b1 || ipc0 !== 32'h4) $display("FAIL stall_pre: got v=%b pc=%h, required 1/00000004", v0, ipc0); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            stall = 1'b1;
            step();
            n_checks++; if (v0 !== 1'b1 || ipc0 !== 32'h4) $display("FAIL stall_hold%0d: got v=%b pc=%h, required 1/00000004", i, v0, ipc0); else n_pass++;
            if (i >= 2) begin
                n_checks++; if (s_req !== 1'b0) $display("FAIL stall_req%0d: got %b, required 0", i, s_req); else n_pass++;
            end
        end
        stall = 1'b0;
        step();
        n_checks++; if (s_req !== 1'b0) $display("FAIL release_req: got %b, required 0", s_req); else n_pass++;
        n_checks++; if (v0 !== 1'b1 || ipc0 !== 32'h8 || instr0 !== mem_word(32'h8)) $display("FAIL release_ifid: got v=%b pc=%h instr=%h, required 1/00000008/%h", v0, ipc0, instr0, mem_word(32'h8)); else n_pass++;
        step();
        n_checks++; if (s_req !== 1'b1 || s_addr !== 32'hC) $display("FAIL resume_addr: got req=%b addr=%h, required 1/0000000c", s_req, s_addr); else n_pass++;
        step();
        n_checks++; if (n_delivered != 4 || exp_q.size() != 0) $display("FAIL stall_delivered: got %0d left %0d, required 4 left 0", n_delivered, exp_q.size()); else n_pass++;
    endtask

    task automatic test_redirect_wait();
        apply_reset();
        m_lat[0] = 3;
        step();
        PCSrc = 1'b1; PCTarget = 32'h103;
        step();
        PCSrc = 1'b0;
        n_checks++; if (pc0 !== 32'h100 || v0 !== 1'b0 || instr0 !== NOP) $display("FAIL redir_wait: got pc=%h v=%b instr=%h, required 00000100/0/%h", pc0, v0, instr0, NOP); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++; if (s_req !== 1'b0) $display("FAIL drain_req%0d: got %b, required 0", i, s_req); else n_pass++;
        end
        n_checks++; if (pc0 !== 32'h100 || v0 !== 1'b0) $display("FAIL drain_discard: got pc=%h v=%b, required 00000100/0", pc0, v0); else n_pass++;
        m_lat[0] = 1;
        step();
        n_checks++; if (s_req !== 1'b1 || s_addr !== 32'h100) $display("FAIL redir_addr: got req=%b addr=%h, required 1/00000100", s_req, s_addr); else n_pass++;
        step();
        n_checks++; if (pc0 !== 32'h104 || n_delivered != 1 || exp_q.size() != 0) $display("FAIL redir_deliver: got pc=%h n=%0d left=%0d, required 00000104/1/0", pc0, n_delivered, exp_q.size()); else n_pass++;
    endtask

    task automatic test_redirect_rvalid();
        apply_reset();
        step();
        PCSrc = 1'b1; PCTarget = 32'h200; stall = 1'b1;
        step();
        PCSrc = 1'b0;
        n_checks++; if (pc0 !== 32'h200 || v0 !== 1'b0 || instr0 !== NOP) $display("FAIL redir_rvalid: got pc=%h v=%b instr=%h, required 00000200/0/%h", pc0, v0, instr0, NOP); else n_pass++;
        step();
        n_checks++; if (s_req !== 1'b1 || s_addr !== 32'h200) $display("FAIL redir_buf_empty: got req=%b addr=%h, required 1/00000200", s_req, s_addr); else n_pass++;
        step();
        n_checks++; if (v0 !== 1'b1 || ipc0 !== 32'h200) $display("FAIL load_invalid_stalled: got v=%b pc=%h, required 1/00000200", v0, ipc0); else n_pass++;
        stall = 1'b0;
        PCSrc = 1'b1; PCTarget = 32'h300;
        step();
        n_checks++; if (v0 !== 1'b0) $display("FAIL redir_flush: got v=%b, required 0", v0); else n_pass++;
        PCTarget = 32'h404;
        step();
        PCSrc = 1'b0;
        step();
        n_checks++; if (s_req !== 1'b1 || s_addr !== 32'h404) $display("FAIL last_target: got req=%b addr=%h, required 1/00000404", s_req, s_addr); else n_pass++;
        step();
        n_checks++; if (n_delivered != 2 || exp_q.size() != 0) $display("FAIL rvalid_delivered: got %0d left %0d, required 2 left 0", n_delivered, exp_q.size()); else n_pass++;
    endtask

    task automatic test_wrap();
        apply_reset();
        n_checks++; if (pc1 !== 32'hFFFF_FFFC) $display("FAIL wrap_reset_pc: got %h, required fffffffc", pc1); else n_pass++;
        step();
        n_checks++; if (s_req1 !== 1'b1 || s_addr1 !== 32'hFFFF_FFFC) $display("FAIL wrap_addr0: got req=%b addr=%h, required 1/fffffffc", s_req1, s_addr1); else n_pass++;
        step();
        n_checks++; if (v1 !== 1'b1 || ipc1 !== 32'hFFFF_FFFC || ip41 !== 32'h0 || instr1 !== mem_word(32'hFFFF_FFFC))
            $display("FAIL wrap_ifid: got v=%b pc=%h pc4=%h instr=%h, required 1/fffffffc/00000000/%h", v1, ipc1, ip41, instr1, mem_word(32'hFFFF_FFFC));
        else n_pass++;
        n_checks++; if (pc1 !== 32'h0) $display("FAIL wrap_pc: got %h, required 00000000", pc1); else n_pass++;
        step();
        n_checks++; if (s_req1 !== 1'b1 || s_addr1 !== 32'h0) $display("FAIL wrap_addr1: got req=%b addr=%h, required 1/00000000", s_req1, s_addr1); else n_pass++;
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        m_lat[0] = 2;
        step();
        reset = 1'b1;
        step();
        n_checks++; if (s_req !== 1'b0) $display("FAIL midrst_req: got %b, required 0", s_req); else n_pass++;
        reset = 1'b0;
        step();
        n_checks++; if (s_req !== 1'b1 || s_addr !== 32'h0) $display("FAIL midrst_refetch: got req=%b addr=%h, required 1/00000000", s_req, s_addr); else n_pass++;
        n_checks++; if (v0 !== 1'b0 || pc0 !== 32'h0) $display("FAIL midrst_ignore: got v=%b pc=%h, required 0/00000000", v0, pc0); else n_pass++;
        step();
        n_checks++; if (v0 !== 1'b0) $display("FAIL midrst_wait: got v=%b, required 0", v0); else n_pass++;
        step();
        n_checks++; if (v0 !== 1'b1 || ipc0 !== 32'h0 || pc0 !== 32'h4) $display("FAIL midrst_deliver: got v=%b pc=%h PC=%h, required 1/00000000/00000004", v0, ipc0, pc0); else n_pass++;
        n_checks++; if (n_delivered != 1 || exp_q.size() != 0) $display("FAIL midrst_count: got %0d left %0d, required 1 left 0", n_delivered, exp_q.size()); else n_pass++;
        m_lat[0] = 1;
    endtask

    initial begin
        n_checks = 0; n_pass = 0; n_delivered = 0;
        reset = 1'b1; PCSrc = 1'b0; stall = 1'b0; PCTarget = 32'h0; gnt_en = 1'b1;
        m_pend = '{1'b0, 1'b0}; m_cnt = '{0, 0}; m_lat = '{1, 1}; m_addr = '{32'h0, 32'h0};
        ifc0.imem_rvalid = 1'b0; ifc0.imem_rdata = 32'h0;
        ifc1.imem_rvalid = 1'b0; ifc1.imem_rdata = 32'h0;
        test_reset();
        test_fetch();
        test_stall();
        test_redirect_wait();
        test_redirect_rvalid();
        test_wrap();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, required finish before 100000 time units");
        $fatal(1);
    end

endmodule
